// File: rtl/exec_branch_unit_pkg.sv
// Shared constants and types for the execute-stage ALU and branch predictor.
package exec_branch_unit_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001,
    ALU_BEQ  = 4'b1010,
    ALU_BNE  = 4'b1011,
    ALU_BLT  = 4'b1100,
    ALU_BGE  = 4'b1101,
    ALU_BLTU = 4'b1110,
    ALU_BGEU = 4'b1111
  } alu_op_e;

  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [1:0] CNT_RESET  = 2'b01;

  // Two-bit saturating counter step toward the resolved direction.
  function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    nxt = cnt;
    if (taken && cnt != 2'b11) nxt = cnt + 2'b01;
    else if (!taken && cnt != 2'b00) nxt = cnt - 2'b01;
    return nxt;
  endfunction

endpackage

// File: rtl/exec_branch_unit_if.sv
// Pipeline-facing signal bundle of the execute/branch unit.
interface exec_branch_unit_if #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned PC_W = 32
);
  logic [XLEN-1:0] op1_i;
  logic [XLEN-1:0] op2_i;
  logic [3:0]      alu_op_i;
  logic [XLEN-1:0] alu_res_o;
  logic            b_flag_o;
  logic            branch_ex_i;
  logic            jump_ex_i;
  logic            ex_valid_i;
  logic [PC_W-1:0] pc_ex_i;
  logic [PC_W-1:0] target_ex_i;
  logic            pred_taken_ex_i;
  logic [PC_W-1:0] pc_if_i;
  logic [4:0]      opcode_if_i;
  logic            taken_ex_o;
  logic            pred_taken_o;
  logic            pc_control_o;
  logic [PC_W-1:0] pc_address_o;
  logic            flush_o;

  modport slave (
    input  op1_i, op2_i, alu_op_i, branch_ex_i, jump_ex_i, ex_valid_i,
           pc_ex_i, target_ex_i, pred_taken_ex_i, pc_if_i, opcode_if_i,
    output alu_res_o, b_flag_o, taken_ex_o, pred_taken_o, pc_control_o,
           pc_address_o, flush_o
  );

  modport master (
    output op1_i, op2_i, alu_op_i, branch_ex_i, jump_ex_i, ex_valid_i,
           pc_ex_i, target_ex_i, pred_taken_ex_i, pc_if_i, opcode_if_i,
    input  alu_res_o, b_flag_o, taken_ex_o, pred_taken_o, pc_control_o,
           pc_address_o, flush_o
  );
endinterface

// File: rtl/exec_alu.sv
// Combinational 64-bit ALU; b_flag is the branch condition for compare codes,
// otherwise the zero flag of the result.
module exec_alu
  import exec_branch_unit_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [3:0]      alu_op_i,
  output logic [XLEN-1:0] alu_res_o,
  output logic            b_flag_o
);

  alu_op_e         op;
  logic [XLEN-1:0] diff;
  logic [5:0]      shamt;
  logic            lt_s;
  logic            lt_u;

  assign op    = alu_op_e'(alu_op_i);
  assign diff  = op1_i - op2_i;
  assign shamt = op2_i[5:0];
  assign lt_s  = $signed(op1_i) < $signed(op2_i);
  assign lt_u  = op1_i < op2_i;

  always_comb begin
    alu_res_o = diff;
    case (op)
      ALU_ADD:  alu_res_o = op1_i + op2_i;
      ALU_SUB:  alu_res_o = diff;
      ALU_AND:  alu_res_o = op1_i & op2_i;
      ALU_OR:   alu_res_o = op1_i | op2_i;
      ALU_XOR:  alu_res_o = op1_i ^ op2_i;
      ALU_SLL:  alu_res_o = op1_i << shamt;
      ALU_SRL:  alu_res_o = op1_i >> shamt;
      ALU_SRA:  alu_res_o = XLEN'($signed(op1_i) >>> shamt);
      ALU_SLT:  alu_res_o = {{(XLEN-1){1'b0}}, lt_s};
      ALU_SLTU: alu_res_o = {{(XLEN-1){1'b0}}, lt_u};
      default:  alu_res_o = diff;
    endcase
  end

  always_comb begin
    b_flag_o = (alu_res_o == '0);
    case (op)
      ALU_BEQ:  b_flag_o = (op1_i == op2_i);
      ALU_BNE:  b_flag_o = (op1_i != op2_i);
      ALU_BLT:  b_flag_o = lt_s;
      ALU_BGE:  b_flag_o = !lt_s;
      ALU_BLTU: b_flag_o = lt_u;
      ALU_BGEU: b_flag_o = !lt_u;
      default:  b_flag_o = (alu_res_o == '0);
    endcase
  end

endmodule

// File: rtl/exec_branch_unit.sv
// Execute-stage ALU, branch resolution and BHT/BTB predictor with fetch
// redirect and flush generation.
module exec_branch_unit
  import exec_branch_unit_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned PC_W  = 32,
  parameter int unsigned IDX_W = 5
) (
  input logic               clk_i,
  input logic               rst_i,
  exec_branch_unit_if.slave bus
);

  localparam int unsigned DEPTH = 1 << IDX_W;
  localparam int unsigned TAG_W = PC_W - IDX_W - 2;

  logic [1:0]      cnt_q [DEPTH];
  logic            v_q   [DEPTH];
  logic [TAG_W-1:0] tag_q [DEPTH];
  logic [PC_W-1:0] tgt_q [DEPTH];

  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic             hit;
  logic             pred;
  logic             mis;
  logic             upd;

  exec_alu #(.XLEN(XLEN)) u_alu (
    .op1_i     (bus.op1_i),
    .op2_i     (bus.op2_i),
    .alu_op_i  (bus.alu_op_i),
    .alu_res_o (bus.alu_res_o),
    .b_flag_o  (bus.b_flag_o)
  );

  assign bus.taken_ex_o = bus.jump_ex_i | (bus.branch_ex_i & bus.b_flag_o);

  assign if_idx = bus.pc_if_i[IDX_W+1:2];
  assign ex_idx = bus.pc_ex_i[IDX_W+1:2];

  // Word-aligned fetch PCs only; a misaligned PC can never have been trained.
  assign hit  = v_q[if_idx] && (tag_q[if_idx] == bus.pc_if_i[PC_W-1:IDX_W+2])
                && (bus.pc_if_i[1:0] == 2'b00);
  assign pred = hit && ((bus.opcode_if_i == OPC_JAL) ||
                        (bus.opcode_if_i == OPC_BRANCH && cnt_q[if_idx][1]));
  assign bus.pred_taken_o = pred;

  assign upd = bus.ex_valid_i && (bus.branch_ex_i || bus.jump_ex_i);
  assign mis = upd && (bus.taken_ex_o != bus.pred_taken_ex_i);

  always_comb begin
    bus.pc_control_o = 1'b0;
    bus.pc_address_o = '0;
    bus.flush_o      = 1'b0;
    if (mis) begin
      bus.pc_control_o = 1'b1;
      bus.pc_address_o = bus.taken_ex_o ? bus.target_ex_i : bus.pc_ex_i + PC_W'(4);
      bus.flush_o      = 1'b1;
    end else if (pred) begin
      bus.pc_control_o = 1'b1;
      bus.pc_address_o = tgt_q[if_idx];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        cnt_q[i] <= CNT_RESET;
        v_q[i]   <= 1'b0;
      end
    end else if (upd) begin
      cnt_q[ex_idx] <= cnt_next(cnt_q[ex_idx], bus.taken_ex_o);
      if (bus.taken_ex_o) v_q[ex_idx] <= 1'b1;
    end
  end

  // Tag/target storage is qualified by v_q, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i && upd && bus.taken_ex_o) begin
      tag_q[ex_idx] <= bus.pc_ex_i[PC_W-1:IDX_W+2];
      tgt_q[ex_idx] <= bus.target_ex_i;
    end
  end

endmodule

// File: tb/tb_exec_branch_unit.sv
// Directed self-checking bench for exec_branch_unit.
module tb_exec_branch_unit;
  import exec_branch_unit_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  exec_branch_unit_if bus ();

  exec_branch_unit dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic br, input logic jp, input logic pr,
                        input logic [31:0] pc, input logic [31:0] tg, input logic [3:0] op,
                        input logic [63:0] a, input logic [63:0] b);
    bus.ex_valid_i      = v;
    bus.branch_ex_i     = br;
    bus.jump_ex_i       = jp;
    bus.pred_taken_ex_i = pr;
    bus.pc_ex_i         = pc;
    bus.target_ex_i     = tg;
    bus.alu_op_i        = op;
    bus.op1_i           = a;
    bus.op2_i           = b;
    #1;
  endtask

  task automatic set_if(input logic [31:0] pc, input logic [4:0] opc);
    bus.pc_if_i     = pc;
    bus.opcode_if_i = opc;
    #1;
  endtask

  task automatic idle_ex();
    set_ex(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'b1011, 64'h0, 64'h0);
  endtask

  task automatic alu(input string tag, input logic [3:0] op, input logic [63:0] a,
                     input logic [63:0] b, input logic [63:0] res, input logic flag);
    set_ex(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, op, a, b);
    check({tag, "_res"}, bus.alu_res_o, res);
    check({tag, "_flag"}, 64'(bus.b_flag_o), 64'(flag));
  endtask

  initial begin
    idle_ex();
    set_if(32'h0, 5'b0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_taken", 64'(bus.taken_ex_o), 64'd0);
    check("rst_pred", 64'(bus.pred_taken_o), 64'd0);
    check("rst_ctrl", 64'(bus.pc_control_o), 64'd0);
    check("rst_addr", 64'(bus.pc_address_o), 64'd0);
    check("rst_flush", 64'(bus.flush_o), 64'd0);
    check("rst_res", bus.alu_res_o, 64'd0);

    alu("sub", 4'b0001, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    alu("sra", 4'b0111, 64'h8000_0000_0000_0000, 64'd4, 64'hF800_0000_0000_0000, 1'b0);
    alu("sltu", 4'b1001, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1);
    alu("slt", 4'b1000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 1'b0);
    alu("blt", 4'b1100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
    alu("bgeu", 4'b1111, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
    alu("add_wrap", 4'b0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1);
    alu("sll_amt", 4'b0101, 64'd1, 64'h43, 64'd8, 1'b0);
    alu("srl", 4'b0110, 64'h8000_0000_0000_0000, 64'd63, 64'd1, 1'b0);
    alu("xor", 4'b0100, 64'hF0F0, 64'h0FF0, 64'hFF00, 1'b0);

    // Cold branch: taken BEQ, predicted not-taken
    set_if(32'h100, 5'b0);
    set_ex(1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h40, 4'b1010, 64'd3, 64'd3);
    check("cold_taken", 64'(bus.taken_ex_o), 64'd1);
    check("cold_ctrl", 64'(bus.pc_control_o), 64'd1);
    check("cold_addr", 64'(bus.pc_address_o), 64'h40);
    check("cold_flush", 64'(bus.flush_o), 64'd1);
    tick();
    idle_ex();
    set_if(32'h10, OPC_BRANCH);
    check("hit_pred", 64'(bus.pred_taken_o), 64'd1);
    check("hit_ctrl", 64'(bus.pc_control_o), 64'd1);
    check("hit_addr", 64'(bus.pc_address_o), 64'h40);
    check("hit_flush", 64'(bus.flush_o), 64'd0);

    // Predicted taken, resolves not-taken, with a simultaneous fetch hit
    set_ex(1'b1, 1'b1, 1'b0, 1'b1, 32'h10, 32'h40, 4'b1011, 64'd3, 64'd3);
    check("mis_pred_also", 64'(bus.pred_taken_o), 64'd1);
    check("mis_taken", 64'(bus.taken_ex_o), 64'd0);
    check("mis_ctrl", 64'(bus.pc_control_o), 64'd1);
    check("mis_addr", 64'(bus.pc_address_o), 64'h14);
    check("mis_flush", 64'(bus.flush_o), 64'd1);
    tick();
    idle_ex();
    check("cnt01_pred", 64'(bus.pred_taken_o), 64'd0);
    set_ex(1'b1, 1'b1, 1'b0, 1'b1, 32'h10, 32'h40, 4'b1011, 64'd3, 64'd3);
    check("mis2_addr", 64'(bus.pc_address_o), 64'h14);
    tick();
    idle_ex();
    check("cnt00_pred", 64'(bus.pred_taken_o), 64'd0);
    check("cnt00_ctrl", 64'(bus.pc_control_o), 64'd0);
    check("cnt00_addr", 64'(bus.pc_address_o), 64'd0);

    // ex_valid low: resolution visible but no redirect and no table update
    set_if(32'h200, OPC_BRANCH);
    set_ex(1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h40, 4'b1010, 64'd3, 64'd3);
    check("nv_taken", 64'(bus.taken_ex_o), 64'd1);
    check("nv_ctrl", 64'(bus.pc_control_o), 64'd0);
    check("nv_flush", 64'(bus.flush_o), 64'd0);
    tick();
    tick();
    idle_ex();
    set_if(32'h10, OPC_BRANCH);
    check("nv_noupd", 64'(bus.pred_taken_o), 64'd0);

    // Saturation at 00: a correctly predicted not-taken keeps 00, one taken gives 01
    set_ex(1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h40, 4'b1011, 64'd3, 64'd3);
    check("nt_ok_ctrl", 64'(bus.pc_control_o), 64'd0);
    tick();
    set_ex(1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h40, 4'b1010, 64'd3, 64'd3);
    tick();
    idle_ex();
    check("sat_lo_pred", 64'(bus.pred_taken_o), 64'd0);
    set_ex(1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h40, 4'b1010, 64'd3, 64'd3);
    tick();
    idle_ex();
    check("cnt10_pred", 64'(bus.pred_taken_o), 64'd1);

    // Tag alias at the same index
    set_if(32'h90, OPC_BRANCH);
    check("alias_pred", 64'(bus.pred_taken_o), 64'd0);
    check("alias_ctrl", 64'(bus.pc_control_o), 64'd0);
    set_if(32'h10, OPC_BRANCH);
    check("alias_kept", 64'(bus.pred_taken_o), 64'd1);

    // Reset wins over a simultaneous taken update
    set_ex(1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h40, 4'b1010, 64'd3, 64'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle_ex();
    set_if(32'h10, OPC_BRANCH);
    check("rst2_pred", 64'(bus.pred_taken_o), 64'd0);
    check("rst2_ctrl", 64'(bus.pc_control_o), 64'd0);

    // JAL in EX fills the BTB; JAL fetch predicts even with counter at 00
    set_if(32'h300, 5'b0);
    set_ex(1'b1, 1'b0, 1'b1, 1'b0, 32'h20, 32'h80, 4'b0000, 64'd0, 64'd1);
    check("jal_taken", 64'(bus.taken_ex_o), 64'd1);
    check("jal_ctrl", 64'(bus.pc_control_o), 64'd1);
    check("jal_addr", 64'(bus.pc_address_o), 64'h80);
    check("jal_flush", 64'(bus.flush_o), 64'd1);
    tick();
    set_ex(1'b1, 1'b1, 1'b0, 1'b0, 32'h20, 32'h80, 4'b1011, 64'd3, 64'd3);
    tick();
    tick();
    idle_ex();
    set_if(32'h20, OPC_JAL);
    check("jalf_pred", 64'(bus.pred_taken_o), 64'd1);
    check("jalf_addr", 64'(bus.pc_address_o), 64'h80);
    check("jalf_flush", 64'(bus.flush_o), 64'd0);
    set_if(32'h20, OPC_BRANCH);
    check("jalf_br_pred", 64'(bus.pred_taken_o), 64'd0);
    set_if(32'h20, 5'b00100);
    check("jalf_other", 64'(bus.pred_taken_o), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/exec_branch_unit.md
Name: exec_branch_unit

Overview:
- Execute-stage compute and control-flow block of the 5-stage RV64 pipeline.
- Combinational 64-bit ALU with branch-condition flag.
- Branch/jump resolution: taken = jump | (branch & flag).
- Dynamic branch predictor: 2-bit BHT plus BTB. It redirects fetch on predicted-taken branches/JAL and on EX-stage mispredicts, and requests pipeline flushes.

Parameters:
- XLEN, 64, datapath width.
- PC_W, 32, PC width.
- IDX_W, 5, predictor index width; table depth = 2^IDX_W, indexed by pc[IDX_W+1:2].

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous active-high reset.
- op1_i  in  XLEN  ALU operand 1 (post-forwarding).
- op2_i  in  XLEN  ALU operand 2 (post-forwarding/immediate mux).
- alu_op_i  in  4  ALU operation code.
- alu_res_o  out  XLEN  ALU result.
- b_flag_o  out  1  branch condition / zero flag.
- branch_ex_i  in  1  EX instruction is a conditional branch.
- jump_ex_i  in  1  EX instruction is JAL.
- ex_valid_i  in  1  EX instruction is valid and seen for the first time; gates table update and mispredict.
- pc_ex_i  in  PC_W  PC of EX instruction.
- target_ex_i  in  PC_W  computed target (pc_ex + imm<<1).
- pred_taken_ex_i  in  1  prediction bit carried down the pipe for the EX instruction.
- pc_if_i  in  PC_W  fetch PC.
- opcode_if_i  in  5  fetched instr[6:2].
- taken_ex_o  out  1  resolved taken.
- pred_taken_o  out  1  fetch-side prediction; the pipeline carries it to EX.
- pc_control_o  out  1  override PC with pc_address_o.
- pc_address_o  out  PC_W  redirect address.
- flush_o  out  1  flush IF/ID, ID/RR and RR/EX latches.

Behaviour:
- ALU (combinational) codes:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
  - 0101 SLL, 0110 SRL, 0111 SRA; shift amount op2[5:0].
  - 1000 SLT, 1001 SLTU; result is 1 or 0, zero-extended.
  - Arithmetic wraps modulo 2^64.
- Compare codes: res = op1-op2, and b_flag is the condition.
  - 1010 BEQ (op1==op2), 1011 BNE.
  - 1100 BLT signed, 1101 BGE signed.
  - 1110 BLTU, 1111 BGEU.
- For codes 0000-1001, b_flag = (res==0).
- taken_ex_o = jump_ex_i | (branch_ex_i & b_flag_o), combinational.
- Tables, one entry per index:
  - cnt[1:0]: 00/01 predict not-taken, 10/11 predict taken.
  - tag = pc[PC_W-1:IDX_W+2].
  - tgt[PC_W-1:0].
  - v (valid bit).
- Fetch prediction (combinational):
  - hit = v & tag match at pc_if_i[IDX_W+1:2].
  - pred_taken_o = hit & ((opcode_if_i==11011) | (opcode_if_i==11000 & cnt[1])).
- Mispredict (combinational):
  - mis = ex_valid_i & (branch_ex_i|jump_ex_i) & (taken_ex_o != pred_taken_ex_i).
- Redirect priority:
  - mis: pc_control_o=1, pc_address_o = taken_ex_o ? target_ex_i : pc_ex_i+4, flush_o=1.
  - else pred_taken_o: pc_control_o=1, pc_address_o = tgt, flush_o=0.
  - else pc_control_o=0, pc_address_o=0, flush_o=0.
- Update at posedge when ex_valid_i & (branch_ex_i|jump_ex_i), at index pc_ex_i[IDX_W+1:2]:
  - cnt saturating +1 if taken, -1 if not (saturates at 11/00).
  - If taken: write tag, tgt=target_ex_i, v=1.
  - The update is visible to fetch on the next cycle. No bypass of a same-cycle write to the fetch lookup.
- Reset (rst_i at posedge): all cnt=01, all v=0. After reset, with inputs idle, every output is 0.
- Reset has priority over a simultaneous update.
- Aliasing is handled by the tag: a mismatch yields no prediction and does not clear the entry.

Decomposition:
- Shared package: ALU opcode constants (ALU_ADD..ALU_BGEU), OPC_BRANCH=5'b11000, OPC_JAL=5'b11011, counter reset constant 2'b01.
- One natural sub-module, exec_alu (the ALU plus flag logic).
- Predictor tables and resolution logic live in the top.

Test Plan:
- ALU sweep:
  - SUB 5-7 → 0xFFFF_FFFF_FFFF_FFFE, flag 0.
  - SRA 0x8000_0000_0000_0000 by 4 → 0xF800_0000_0000_0000.
  - SLTU -1,1 → 0.
  - BLT -1,1 → flag 1.
- Cold branch: pc_ex=0x10, target 0x40, BEQ equal, pred_taken_ex=0, ex_valid=1.
  - Required: taken_ex=1, pc_control=1, pc_address=0x40, flush=1.
  - Next cycle, fetch pc_if=0x10 with opcode 11000 → pred_taken=1, address 0x40, flush=0.
- Predicted taken but resolves not-taken (BNE equal, pred_taken_ex=1):
  - Required: address = pc_ex+4 = 0x14, flush=1.
  - After 2 such updates cnt=00 and fetch at 0x10 predicts not-taken.
- Same cycle: fetch hit and EX mispredict → EX redirect wins, flush=1. Also check: ex_valid=0 with mismatch → no redirect and no update.
- Reset after training → fetch at 0x10 gives pred_taken=0. Also check: tag alias pc_if=0x90 (same index) → no prediction.
- JAL in EX: jump=1, pred=0 → redirect to target and BTB filled. Next fetch of the same PC with opcode 11011 predicts regardless of cnt.
